fifo: RTL and testbench

- Synchronous single-clock first-in/first-out buffer for data words of parameterised width and depth.
- Producer writes with push_i/dato_i; consumer reads with pop_i, and the popped word is presented registered on dato_o.
- Generic queueing element used between pipeline stages; status flags let neighbours avoid overflow and underflow.

---
 rtl/fifo_mem.sv | 25 ++
 rtl/fifo.sv | 75 +++++++
 tb/tb_fifo.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/fifo_mem.sv
// Storage array for the fifo. It has a synchronous write port and a combinational read port.
module fifo_mem #(
    parameter int width = 16,
    parameter int depth = 8,
    parameter int PTR_W = 3
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] wr_addr,
    input  logic [width-1:0] wr_data,
    input  logic [PTR_W-1:0] rd_addr,
    output logic [width-1:0] rd_data
);

    logic [width-1:0] mem [depth];

    // NOTE: the array is deliberately left out of reset. Occupancy is tracked by the
    // pointers and count, so stale words are never observed, and the array maps to plain flops or RAM.
    always_ff @(posedge clk) begin
        if (we) mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo.sv
// Single-clock fifo with a registered read port, occupancy count and overflow/underflow pulses.
// It holds any integer depth of 2 or more. Pointers wrap by explicit compare.
module fifo #(
    parameter int width = 16,
    parameter int depth = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [width-1:0]           dato_i,
    output logic [width-1:0]           dato_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(depth+1)-1:0] count_o,
    output logic                       overflow_o,
    output logic                       underflow_o
);

    localparam int PTR_W = (depth > 2) ? $clog2(depth) : 1;
    localparam int CNT_W = $clog2(depth + 1);

    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [width-1:0] rd_data;
    logic             push_v, pop_v, push_ok, pop_ok;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(depth - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Requests are forced low while reset is held, so X on the inputs cannot reach the state.
    assign push_v  = push_i & rst_n;
    assign pop_v   = pop_i & rst_n;
    assign pop_ok  = pop_v & ~empty_o;
    assign push_ok = push_v & (~full_o | pop_v);

    assign full_o  = (count_o == CNT_W'(depth));
    assign empty_o = (count_o == '0);

    fifo_mem #(.width(width), .depth(depth), .PTR_W(PTR_W)) u_mem (
        .clk     (clk),
        .we      (push_ok),
        .wr_addr (wr_ptr),
        .wr_data (dato_i),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    // NOTE: every register here is updated with non-blocking assignments. Because of that,
    // a simultaneous push and pop on a full fifo reads the old word before the write lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_o     <= '0;
            dato_o      <= '0;
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= next_ptr(wr_ptr);
            if (pop_ok) begin
                rd_ptr <= next_ptr(rd_ptr);
                dato_o <= rd_data;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_o <= count_o + CNT_W'(1);
                2'b01:   count_o <= count_o - CNT_W'(1);
                default: count_o <= count_o;
            endcase
            overflow_o  <= push_v & ~push_ok;
            underflow_o <= pop_v & empty_o;
        end
    end

endmodule

// File: tb/tb_fifo.sv
// Testbench for fifo. A queue-based reference model predicts every cycle, and a separate monitor
// checks the fifo against a scoreboard of those predictions.
module tb_fifo;

    localparam int W     = 16;
    localparam int D     = 8;
    localparam int CNT_W = $clog2(D + 1);

    typedef struct {
        int            count;
        logic          ovf;
        logic          unf;
        logic [W-1:0]  dato;
    } status_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             push_i = 1'b0;
    logic             pop_i = 1'b0;
    logic [W-1:0]     dato_i = '0;
    logic [W-1:0]     dato_o;
    logic             full_o, empty_o;
    logic [CNT_W-1:0] count_o;
    logic             overflow_o, underflow_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] model_q[$];
    logic [W-1:0] data_q[$];
    status_t      status_q[$];
    logic [W-1:0] last_dato;

    fifo #(.width(W), .depth(D)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push_i),
        .pop_i       (pop_i),
        .dato_i      (dato_i),
        .dato_o      (dato_o),
        .full_o      (full_o),
        .empty_o     (empty_o),
        .count_o     (count_o),
        .overflow_o  (overflow_o),
        .underflow_o (underflow_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model one cycle from the fifo rules. A pop takes the oldest word, and a push is refused
    // only when the fifo is full and no pop happens in the same cycle.
    task automatic cycle(input logic push, input logic pop, input logic [W-1:0] data);
        status_t s;
        bit      pop_acc, push_acc;
        @(negedge clk);
        push_i = push;
        pop_i  = pop;
        dato_i = data;
        pop_acc  = pop && (model_q.size() > 0);
        push_acc = push && ((model_q.size() < D) || pop);
        s.ovf = push && !push_acc;
        s.unf = pop && (model_q.size() == 0);
        if (pop_acc) begin
            last_dato = model_q.pop_front();
            data_q.push_back(last_dato);
        end
        if (push_acc) model_q.push_back(data);
        s.count = model_q.size();
        s.dato  = last_dato;
        status_q.push_back(s);
    endtask

    task automatic release_reset();
        status_t s;
        @(negedge clk);
        push_i = 1'b0;
        pop_i  = 1'b0;
        rst_n  = 1'b1;
        s.count = 0;
        s.ovf   = 1'b0;
        s.unf   = 1'b0;
        s.dato  = '0;
        status_q.push_back(s);
    endtask

    task automatic clear_model();
        model_q.delete();
        data_q.delete();
        status_q.delete();
        last_dato = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_dato"},  32'(dato_o), 0);
        check({tag, "_empty"}, 32'(empty_o), 1);
        check({tag, "_full"},  32'(full_o), 0);
        check({tag, "_count"}, 32'(count_o), 0);
        check({tag, "_ovf"},   32'(overflow_o), 0);
        check({tag, "_unf"},   32'(underflow_o), 0);
    endtask

    // Monitor: compare the flags and dato_o every cycle, and pop the scoreboard on each accepted pop.
    initial begin : monitor
        status_t      s;
        logic [W-1:0] exp_d;
        bit           pop_seen;
        forever begin
            @(posedge clk);
            if (!rst_n) continue;
            pop_seen = pop_i && !empty_o;
            #1;
            if (!rst_n) continue;
            if (status_q.size() == 0) begin
                check("status_sync", 32'(status_q.size()), 1);
            end else begin
                s = status_q.pop_front();
                check("count", 32'(count_o), 32'(s.count));
                check("full", 32'(full_o), 32'(s.count == D));
                check("empty", 32'(empty_o), 32'(s.count == 0));
                check("overflow", 32'(overflow_o), 32'(s.ovf));
                check("underflow", 32'(underflow_o), 32'(s.unf));
                check("dato_hold", 32'(dato_o), 32'(s.dato));
            end
            if (pop_seen) begin
                if (data_q.size() == 0) begin
                    check("pop_unexpected", 32'(data_q.size()), 1);
                end else begin
                    exp_d = data_q.pop_front();
                    check("pop_data", 32'(dato_o), 32'(exp_d));
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        clear_model();
        #12;
        check_reset_outputs("reset");
        release_reset();
        repeat (2) cycle(0, 0, '0);

        cycle(1, 0, 16'h0006);
        cycle(1, 0, 16'h000A);
        cycle(0, 1, '0);
        cycle(0, 1, '0);

        for (int i = 1; i <= 8; i++) cycle(1, 0, W'(i));
        cycle(1, 0, 16'h0009);
        for (int i = 0; i < 8; i++) cycle(0, 1, '0);

        rst_n = 1'b0;
        clear_model();
        release_reset();
        cycle(0, 1, '0);
        cycle(1, 1, 16'h0033);
        cycle(0, 1, '0);

        for (int i = 0; i < 8; i++) cycle(1, 0, W'(16'h10 + i));
        for (int i = 0; i < 4; i++) cycle(1, 1, 16'h0020);
        for (int i = 0; i < 8; i++) cycle(0, 1, 16'h0020);
        cycle(0, 1, 16'h0020);

        for (int i = 0; i < 3; i++) cycle(1, 0, W'(16'h40 + i));
        cycle(0, 1, '0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        clear_model();
        release_reset();
        cycle(0, 1, '0);

        for (int i = 0; i < 1500; i++) begin
            int pp = (i / 300) % 3;
            logic push = ($urandom_range(99) < (pp == 0 ? 70 : (pp == 1 ? 30 : 50)));
            logic pop  = ($urandom_range(99) < (pp == 0 ? 30 : (pp == 1 ? 70 : 50)));
            cycle(push, pop, W'($urandom));
        end
        cycle(0, 0, '0);
        @(negedge clk);
        check("sb_status_drained", 32'(status_q.size()), 0);
        check("sb_data_drained", 32'(data_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
